// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port, shared-memory port and error/stall status
// of mem_port_arbiter. The slave modport is the arbiter side; master is the environment.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        d_stall;
  logic        err_clr;
  logic        align_err;
  logic        timeout_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata, err_clr,
    output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           if_stall, d_stall, align_err, timeout_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata, err_clr,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           if_stall, d_stall, align_err, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, with
// misalignment rejection, access timeout and a cap on consecutive data grants.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate pending requests
// BUSY_IF | fetch access issued, waiting for mem_ready or timeout
// BUSY_D  | data access issued, waiting for mem_ready or timeout
// ERR_ACK | misaligned request granted; acknowledge with zero data
module mem_port_arbiter #(
  parameter int TIMEOUT      = 16,
  parameter int MAX_DATA_RUN = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, ERR_ACK} state_t;

  state_t      state;
  logic        err_for_d;
  logic [7:0]  data_run;
  logic [15:0] busy_cnt;

  logic any_ack;
  logic if_valid;
  logic d_valid;
  logic grant_d;
  logic grant_if;
  logic busy_done;

  assign bus.if_stall = bus.if_req & ~bus.if_ack;
  assign bus.d_stall  = bus.d_req & ~bus.d_ack;

  // The ack cycle is a settling cycle: the acked requester is still holding req,
  // and pausing arbitration there lets the data-run cap actually take effect.
  assign any_ack  = bus.if_ack | bus.d_ack;
  assign if_valid = bus.if_req & ~any_ack;
  assign d_valid  = bus.d_req & ~any_ack;
  assign grant_d  = d_valid & (~if_valid | (data_run != 8'(MAX_DATA_RUN)));
  assign grant_if = if_valid & ~grant_d;

  assign busy_done = bus.mem_ready | (busy_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      err_for_d       <= 1'b0;
      data_run        <= '0;
      busy_cnt        <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.if_ack      <= 1'b0;
      bus.d_ack       <= 1'b0;
      bus.if_rdata    <= '0;
      bus.d_rdata     <= '0;
      bus.align_err   <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.if_ack   <= 1'b0;
      bus.d_ack    <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata  <= '0;
      // A flag set later in this block overrides a coincident clear.
      if (bus.err_clr) begin
        bus.align_err   <= 1'b0;
        bus.timeout_err <= 1'b0;
      end
      if (!bus.if_req) data_run <= '0;

      case (state)
        IDLE: begin
          busy_cnt <= '0;
          if (grant_d) begin
            if (bus.if_req) data_run <= data_run + 8'd1;
            if (bus.d_addr[1:0] != 2'b00) begin
              err_for_d <= 1'b1;
              state     <= ERR_ACK;
            end else begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              state         <= BUSY_D;
            end
          end else if (grant_if) begin
            data_run <= '0;
            if (bus.if_addr[1:0] != 2'b00) begin
              err_for_d <= 1'b0;
              state     <= ERR_ACK;
            end else begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= '0;
              state         <= BUSY_IF;
            end
          end
        end

        BUSY_IF, BUSY_D: begin
          if (busy_done) begin
            bus.mem_req <= 1'b0;
            state       <= IDLE;
            if (state == BUSY_D) bus.d_ack  <= 1'b1;
            else                 bus.if_ack <= 1'b1;
            if (bus.mem_ready) begin
              if (state == BUSY_D) bus.d_rdata  <= bus.mem_rdata;
              else                 bus.if_rdata <= bus.mem_rdata;
            end else begin
              bus.timeout_err <= 1'b1;
            end
          end else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
        end

        ERR_ACK: begin
          bus.align_err <= 1'b1;
          if (err_for_d) bus.d_ack  <= 1'b1;
          else           bus.if_ack <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares them; a small memory model answers mem_req.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(16), .MAX_DATA_RUN(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // memory model controls
  int          mem_delay    = 1;
  bit          mem_hang     = 1'b0;
  bit          mem_force    = 1'b0;
  bit          use_override = 1'b0;
  logic [31:0] override_data = '0;
  int          req_cycles   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] auto_data(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0000;
  endfunction

  // memory: ready in the mem_delay-th cycle of mem_req unless hung
  always @(negedge clk) begin
    if (bus.mem_req) req_cycles++;
    else req_cycles = 0;
    if (mem_force) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
    end else if (bus.mem_req && !mem_hang && req_cycles == mem_delay) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = use_override ? override_data : auto_data(bus.mem_addr);
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_ack && bus.d_ack) begin
      checks++;
      errors++;
      $display("FAIL dual_ack: both acks high at %0t", $time);
    end else if (bus.if_ack || bus.d_ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: if_ack=%b d_ack=%b with empty queue at %0t",
                 bus.if_ack, bus.d_ack, $time);
      end else begin
        e = sb_q.pop_front();
        check("ack_port_is_d", {31'd0, bus.d_ack}, {31'd0, e.is_d});
        check("ack_rdata", bus.d_ack ? bus.d_rdata : bus.if_rdata, e.rdata);
      end
    end
    if (!bus.if_ack) check("if_rdata_idle_zero", bus.if_rdata, 32'h0);
    if (!bus.d_ack)  check("d_rdata_idle_zero", bus.d_rdata, 32'h0);
  end

  // Wait for an ack; counts cycles from the request cycle and mem_req-high cycles.
  task automatic wait_ack(output int cycles, output int req_hi, input bit chk_store,
                          input logic [31:0] s_addr, input logic [31:0] s_wdata);
    cycles = -1;
    req_hi = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        req_hi++;
        if (chk_store)
          check("store_bus_stable", {bus.mem_we, bus.mem_addr ^ s_addr, bus.mem_wdata ^ s_wdata},
                {1'b1, 32'h0, 32'h0});
      end
      if (bus.if_ack || bus.d_ack) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack within 60 cycles at %0t", $time);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] rdata);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rh;
    rst_n       = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.err_clr = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {27'd0, bus.mem_req, bus.if_ack, bus.d_ack, bus.align_err, bus.timeout_err}, 32'h0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single fetch, memory ready in 3rd cycle
    mem_delay = 3; use_override = 1'b1; override_data = 32'h1234_5678;
    push(1'b0, 32'h1234_5678);
    @(posedge clk);
    #1 bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    #1 check("if_stall_pending", {31'd0, bus.if_stall}, 32'd1);
    wait_ack(cyc, rh, 1'b0, '0, '0);
    check("fetch_total_cycles", cyc + 1, 32'd5);
    check("fetch_mem_req_cycles", rh, 32'd3);
    check("if_stall_at_ack", {31'd0, bus.if_stall}, 32'd0);
    bus.if_req = 1'b0;
    use_override = 1'b0;

    // store: mem bus stable until ready, d_rdata equals mem_rdata
    push(1'b1, auto_data(32'h100));
    @(posedge clk);
    #1 bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hCAFE_F00D;
    wait_ack(cyc, rh, 1'b1, 32'h100, 32'hCAFE_F00D);
    check("store_mem_req_cycles", rh, 32'd3);
    bus.d_req = 1'b0; bus.d_we = 1'b0;

    // misaligned data load
    push(1'b1, 32'h0);
    @(posedge clk);
    #1 bus.d_req = 1'b1; bus.d_addr = 32'h0000_0006;
    wait_ack(cyc, rh, 1'b0, '0, '0);
    check("misalign_ack_latency", cyc, 32'd2);
    check("misalign_no_mem_req", rh, 32'd0);
    check("align_err_set", {31'd0, bus.align_err}, 32'd1);
    bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    check("align_err_sticky", {31'd0, bus.align_err}, 32'd1);
    @(posedge clk); #1 bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
    @(negedge clk);
    check("align_err_cleared", {31'd0, bus.align_err}, 32'd0);

    // err_clr held while a new misalignment occurs: set wins
    push(1'b1, 32'h0);
    @(posedge clk);
    #1 bus.d_req = 1'b1; bus.d_addr = 32'h0000_000A; bus.err_clr = 1'b1;
    wait_ack(cyc, rh, 1'b0, '0, '0);
    check("align_err_set_over_clr", {31'd0, bus.align_err}, 32'd1);
    bus.d_req = 1'b0; bus.err_clr = 1'b0;

    // timeout: memory never ready
    mem_hang = 1'b1;
    push(1'b0, 32'h0);
    @(posedge clk);
    #1 bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    wait_ack(cyc, rh, 1'b0, '0, '0);
    check("timeout_mem_req_cycles", rh, 32'd16);
    check("timeout_err_set", {31'd0, bus.timeout_err}, 32'd1);
    bus.if_req = 1'b0;
    mem_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ready_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
    end
    mem_force = 1'b0;
    mem_hang  = 1'b0;
    @(posedge clk); #1 bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
    @(negedge clk);
    check("both_flags_cleared", {30'd0, bus.align_err, bus.timeout_err}, 32'd0);

    // misaligned fetch leaves align_err set going into the reset test
    push(1'b0, 32'h0);
    @(posedge clk);
    #1 bus.if_req = 1'b1; bus.if_addr = 32'h0000_0002;
    wait_ack(cyc, rh, 1'b0, '0, '0);
    check("fetch_misalign_latency", cyc, 32'd2);
    bus.if_req = 1'b0;

    // reset during the second BUSY cycle
    mem_hang = 1'b1;
    @(posedge clk);
    #1 bus.d_req = 1'b1; bus.d_addr = 32'h0000_0200;
    begin
      int seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        @(negedge clk);
        if (bus.mem_req) seen = 1;
      end
      check("busy_entered", seen, 32'd1);
    end
    @(posedge clk);
    #1 rst_n = 1'b0; bus.d_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy_ctrl", {27'd0, bus.mem_req, bus.if_ack, bus.d_ack, bus.align_err, bus.timeout_err}, 32'h0);
    mem_hang  = 1'b0;
    mem_delay = 1;
    repeat (2) @(negedge clk);
    check("rst_busy_no_ack_queue", sb_q.size(), 32'd0);

    // fresh request after reset at minimum latency
    push(1'b1, auto_data(32'h204));
    @(posedge clk);
    #1 bus.d_req = 1'b1; bus.d_addr = 32'h0000_0204;
    wait_ack(cyc, rh, 1'b0, '0, '0);
    check("post_reset_min_latency", cyc, 32'd2);
    check("post_reset_mem_req_cycles", rh, 32'd1);
    bus.d_req = 1'b0;

    // both held, memory always ready: D,D,IF,D,D,IF
    push(1'b1, auto_data(32'h300));
    push(1'b1, auto_data(32'h300));
    push(1'b0, auto_data(32'h080));
    push(1'b1, auto_data(32'h300));
    push(1'b1, auto_data(32'h300));
    push(1'b0, auto_data(32'h080));
    @(posedge clk);
    #1 bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.if_req = 1'b1; bus.if_addr = 32'h080;
    begin
      int done = 0;
      for (int i = 0; i < 100 && done == 0; i++) begin
        @(negedge clk);
        #1;
        if (sb_q.size() == 0) done = 1;
      end
      check("arb_sequence_complete", done, 32'd1);
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    repeat (6) @(negedge clk);
    check("arb_no_extra_grant", {31'd0, bus.mem_req}, 32'd0);
    check("final_queue_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: TIMEOUT, default 16, maximum BUSY cycles waiting for mem_ready; MAX_DATA_RUN, default 2, maximum consecutive data grants while fetch waits.
REQ-002 SHALL have ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  32  fetched word; valid only while if_ack=1.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  32  load data; valid only while d_ack=1.
- mem_req  out  1  request to the shared single-port memory.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  32  memory read data.
- if_stall  out  1  combinational: if_req & ~if_ack.
- d_stall  out  1  combinational: d_req & ~d_ack.
- err_clr  in  1  clears the sticky error flags.
- align_err  out  1  sticky: a misaligned request occurred.
- timeout_err  out  1  sticky: a memory access timed out.

Function
REQ-003 SHALL implement states IDLE, BUSY_IF, BUSY_D and ERR_ACK.
REQ-004 In IDLE, SHALL ignore a requester's req in any cycle where that requester's ack is high.
REQ-005 In IDLE, if only one valid request is present, SHALL grant it; if both are present, SHALL grant data unless data_run==MAX_DATA_RUN, in which case SHALL grant fetch.
REQ-006 data_run SHALL increment on each data grant made while if_req is pending, SHALL clear on a fetch grant, and SHALL clear in any cycle where if_req=0.
REQ-007 On grant of an aligned request (addr[1:0]==0), at the same edge SHALL register mem_req=1 and mem_addr, mem_we and mem_wdata from the granted requester, and SHALL go to BUSY_IF or BUSY_D; for fetch grants mem_we SHALL be 0.
REQ-008 In BUSY_x, SHALL hold the mem_* outputs stable until mem_ready=1.
REQ-009 On mem_ready=1 in BUSY_x, at that edge SHALL drop mem_req, register mem_rdata to x_rdata, pulse x_ack for exactly one cycle, and return to IDLE.
REQ-010 Minimum latency SHALL be: request seen in cycle 0, mem_req high in cycle 1, ack in cycle 2 when mem_ready=1 in cycle 1.
REQ-011 On grant of a misaligned request, SHALL perform no memory access, SHALL go to ERR_ACK, and SHALL pulse ack in the next cycle with rdata=0 and align_err=1; the grant SHALL count for arbitration.
REQ-012 A BUSY cycle counter SHALL start at 0 on grant; if it reaches TIMEOUT with no mem_ready, SHALL drop mem_req, pulse ack with rdata=0, set timeout_err and return to IDLE.
REQ-013 mem_ready seen outside the BUSY states SHALL be ignored.
REQ-014 err_clr=1 SHALL clear both error flags at the next edge; if err_clr coincides with a new error, the flag SHALL be set.
REQ-015 x_rdata SHALL be 0 whenever x_ack=0.

Reset
REQ-016 While rst_n=0 at a rising edge: state=IDLE; all registered outputs, counters, data_run and error flags=0.
REQ-017 Reset during BUSY SHALL abandon the access: mem_req low after that edge, no ack issued.

Verification
REQ-018 Single fetch at 0x0000_0010, memory ready after 3 cycles with 0x1234_5678 -> mem_req high 3 cycles, if_ack pulse with if_rdata=0x1234_5678, 5 cycles total from request.
REQ-019 if_req and d_req held continuously, memory always ready -> grant order D,D,IF,D,D,IF; no back-to-back duplicate of a completed request.
REQ-020 d_req with d_addr=0x0000_0006 -> no mem_req, d_ack 2 cycles after request, d_rdata=0, align_err=1 until err_clr.
REQ-021 mem_ready held 0 -> mem_req drops after 16 BUSY cycles, ack with data 0, timeout_err=1; late mem_ready afterwards ignored.
REQ-022 rst_n=0 in the second BUSY cycle -> mem_req=0, no ack, flags 0; a fresh request afterwards completes normally.
REQ-023 Store d_we=1, d_addr=0x100, d_wdata=0xCAFE_F00D -> mem_we=1, mem_addr=0x100 and mem_wdata=0xCAFE_F00D stable until mem_ready; d_ack with d_rdata equal to mem_rdata.
